line_drawer: RTL and testbench

LINE_DRAWER -- requirements
Module: line_drawer

---
 rtl/plotter_pkg.sv | 25 ++
 rtl/line_drawer.sv | 127 ++++++++++++
 tb/tb_line_drawer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/plotter_pkg.sv
// Shared definitions for the plotter blocks:
// screen geometry, coordinate widths and the line FSM states.
package plotter_pkg;

    localparam int HOR_ACTIVE_PIXELS_DEF = 640;
    localparam int VER_ACTIVE_PIXELS_DEF = 480;

    // Bits needed to address n pixels along one axis.
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed error term width: two headroom bits over the wider axis
    // so that both err and 2*err stay in range for any endpoints.
    function automatic int err_width(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 2;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;

endpackage

// File: rtl/line_drawer.sv
// Bresenham line rasteriser: one accepted start produces every pixel
// from (x1,y1) to (x2,y2) inclusive, one per cycle under pixel_ready.
module line_drawer
    import plotter_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = HOR_ACTIVE_PIXELS_DEF,
    parameter int VER_ACTIVE_PIXELS = VER_ACTIVE_PIXELS_DEF,
    localparam int X_WIDTH = coord_width(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = coord_width(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               ready,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    input  logic [X_WIDTH-1:0] x2,
    input  logic [Y_WIDTH-1:0] y2,
    output logic [X_WIDTH-1:0] pixel_x,
    output logic [Y_WIDTH-1:0] pixel_y,
    output logic               pixel_valid,
    input  logic               pixel_ready
);

    localparam int ERR_W = err_width(X_WIDTH, Y_WIDTH);

    state_t state;

    logic [X_WIDTH-1:0] x_a, x_b;
    logic [Y_WIDTH-1:0] y_a, y_b;

    logic signed [ERR_W-1:0] dx, dy, err;
    logic                    sx_neg, sy_neg;

    logic [X_WIDTH-1:0]      dx_abs;
    logic [Y_WIDTH-1:0]      dy_abs;
    logic signed [ERR_W-1:0] dx_s, dy_s;
    logic signed [ERR_W-1:0] e2, err_nxt;
    logic                    step_x, step_y;
    logic                    at_end;

    assign ready = (state == IDLE);

    // Setup deltas from the captured endpoints and the per-pixel step.
    always_comb begin
        dx_abs  = (x_b >= x_a) ? (x_b - x_a) : (x_a - x_b);
        dy_abs  = (y_b >= y_a) ? (y_b - y_a) : (y_a - y_b);
        dx_s    = $signed(ERR_W'(dx_abs));
        dy_s    = $signed(ERR_W'(dy_abs));
        e2      = err <<< 1;
        step_x  = (e2 >= -dy);
        step_y  = (e2 <= dx);
        err_nxt = err;
        if (step_x) begin
            err_nxt = err_nxt - dy;
        end
        if (step_y) begin
            err_nxt = err_nxt + dx;
        end
        at_end  = (pixel_x == x_b) && (pixel_y == y_b);
    end

    // Line FSM: capture, one setup cycle, then walk the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            x_a         <= '0;
            x_b         <= '0;
            y_a         <= '0;
            y_b         <= '0;
            dx          <= '0;
            dy          <= '0;
            err         <= '0;
            sx_neg      <= 1'b0;
            sy_neg      <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_a   <= x1;
                        y_a   <= y1;
                        x_b   <= x2;
                        y_b   <= y2;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    dx          <= dx_s;
                    dy          <= dy_s;
                    err         <= dx_s - dy_s;
                    sx_neg      <= (x_b < x_a);
                    sy_neg      <= (y_b < y_a);
                    pixel_x     <= x_a;
                    pixel_y     <= y_a;
                    pixel_valid <= 1'b1;
                    state       <= DRAW;
                end
                DRAW: begin
                    if (pixel_ready) begin
                        if (at_end) begin
                            pixel_valid <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            err <= err_nxt;
                            if (step_x) begin
                                pixel_x <= sx_neg ? pixel_x - X_WIDTH'(1)
                                                  : pixel_x + X_WIDTH'(1);
                            end
                            if (step_y) begin
                                pixel_y <= sy_neg ? pixel_y - Y_WIDTH'(1)
                                                  : pixel_y + Y_WIDTH'(1);
                            end
                        end
                    end
                end
                default: begin
                    pixel_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_drawer.sv
// Randomised bench for line_drawer against a plain integer
// Bresenham reference, with directed corner lines and backpressure.
module tb_line_drawer;
    import plotter_pkg::*;

    localparam int XW = coord_width(HOR_ACTIVE_PIXELS_DEF);
    localparam int YW = coord_width(VER_ACTIVE_PIXELS_DEF);
    localparam int XMAX = HOR_ACTIVE_PIXELS_DEF - 1;
    localparam int YMAX = VER_ACTIVE_PIXELS_DEF - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ready;
    logic [XW-1:0] x1 = '0, x2 = '0;
    logic [YW-1:0] y1 = '0, y2 = '0;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic          pixel_valid;
    logic          pixel_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    line_drawer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ready      (ready),
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int pk(input int x, input int y);
        return x * 1024 + y;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference: textbook integer Bresenham, all eight octants.
    task automatic model(input int ax, input int ay, input int bx, input int by);
        int dx, dy, sx, sy, err, e2, x, y;
        exp_q.delete();
        dx  = iabs(bx - ax);
        dy  = iabs(by - ay);
        sx  = (bx >= ax) ? 1 : -1;
        sy  = (by >= ay) ? 1 : -1;
        err = dx - dy;
        x   = ax;
        y   = ay;
        for (int n = 0; n < 4096; n++) begin
            exp_q.push_back(pk(x, y));
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= -dy) begin
                err -= dy;
                x   += sx;
            end
            if (e2 <= dx) begin
                err += dx;
                y   += sy;
            end
        end
    endtask

    task automatic scramble();
        x1 = XW'($urandom_range(0, XMAX));
        x2 = XW'($urandom_range(0, XMAX));
        y1 = YW'($urandom_range(0, YMAX));
        y2 = YW'($urandom_range(0, YMAX));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", int'(ready), 1);
    endtask

    // Issue one line and check the whole pixel stream.
    // mode 0: always ready, 1: pattern 1,0,0 repeating, 2: random.
    task automatic draw(input int ax, input int ay, input int bx,
                        input int by, input int mode);
        int want_n, got_n, idx, cyc, budget;
        int last;
        bit stalled, pr;
        model(ax, ay, bx, by);
        want_n = ((iabs(bx - ax) > iabs(by - ay)) ?
                  iabs(bx - ax) : iabs(by - ay)) + 1;
        budget = want_n * 8 + 20;
        wait_ready();
        x1 = XW'(ax);
        y1 = YW'(ay);
        x2 = XW'(bx);
        y2 = YW'(by);
        start = 1'b1;
        @(negedge clk);
        start = 1'(($urandom % 2));
        scramble();
        check("setup_valid", int'(pixel_valid), 0);
        check("setup_ready", int'(ready), 0);
        @(negedge clk);
        check("first_valid", int'(pixel_valid), 1);
        got_n = 0;
        idx = 0;
        cyc = 0;
        stalled = 0;
        last = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            check("valid", int'(pixel_valid), 1);
            if (stalled) check("stable", pk(pixel_x, pixel_y), last);
            unique case (mode)
                0: pr = 1'b1;
                1: pr = (idx % 3 == 0);
                default: pr = ($urandom % 4 != 0);
            endcase
            pixel_ready = pr;
            if (pr) begin
                check("pixel", pk(pixel_x, pixel_y), exp_q.pop_front());
                got_n++;
                stalled = 0;
                start = (exp_q.size() == 0) ? 1'b0 : 1'(($urandom % 2));
            end else begin
                stalled = 1;
                last = pk(pixel_x, pixel_y);
                start = 1'(($urandom % 2));
            end
            scramble();
            idx++;
            cyc++;
            @(negedge clk);
        end
        if (cyc >= budget) check("timeout", 0, 1);
        start = 1'b0;
        check("done_valid", int'(pixel_valid), 0);
        check("done_ready", int'(ready), 1);
        check("count", got_n, want_n);
    endtask

    task automatic reset_midline();
        wait_ready();
        model(0, 0, XMAX, 0);
        x1 = '0;
        y1 = '0;
        x2 = XW'(XMAX);
        y2 = '0;
        pixel_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("rst_pixel", pk(pixel_x, pixel_y), exp_q.pop_front());
            @(negedge clk);
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("rst_valid", int'(pixel_valid), 0);
        check("rst_ready", int'(ready), 1);
        check("rst_x", int'(pixel_x), 0);
        check("rst_y", int'(pixel_y), 0);
        @(negedge clk);
        check("rst_idle_valid", int'(pixel_valid), 0);
        draw(0, 0, 2, 1, 0);
    endtask

    initial begin
        int ax, ay, bx, by;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("por_ready", int'(ready), 1);
        check("por_valid", int'(pixel_valid), 0);
        check("por_x", int'(pixel_x), 0);
        check("por_y", int'(pixel_y), 0);

        draw(0, 5, 4, 5, 0);
        draw(3, 7, 1, 0, 0);
        draw(10, 10, 10, 10, 0);
        draw(0, 0, 3, 3, 1);
        draw(XMAX, YMAX, 0, 0, 2);
        draw(0, YMAX, XMAX, 0, 0);
        reset_midline();

        for (int i = 0; i < 400; i++) begin
            ax = $urandom_range(0, XMAX);
            ay = $urandom_range(0, YMAX);
            if (i % 50 == 0) begin
                bx = $urandom_range(0, XMAX);
                by = $urandom_range(0, YMAX);
            end else begin
                bx = ax + $urandom_range(0, 80) - 40;
                by = ay + $urandom_range(0, 80) - 40;
                bx = (bx < 0) ? 0 : (bx > XMAX) ? XMAX : bx;
                by = (by < 0) ? 0 : (by > YMAX) ? YMAX : by;
            end
            draw(ax, ay, bx, by, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
